// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file debug sequencer.
// State encoding and default widths used by the top and the bench.
package regfile_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DUMP = 2'd2
   } state_e;

endpackage

// File: rtl/vdff_w_load.sv
// Load-enable register with asynchronous active-low clear.
// Holds its value unless load is high on the rising edge.
module vdff_w_load #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = load ? d : q_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/regfile_dbg_seq.sv
// Debug sequencer: streams words into (load) or out of (dump)
// a window of consecutive register-file entries.
module regfile_dbg_seq
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_op,
   input  logic [ADDR_W-1:0] cmd_start,
   input  logic [ADDR_W-1:0] cmd_len,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [DATA_W-1:0] ld_data,
   output logic              dp_valid,
   input  logic              dp_ready,
   output logic [DATA_W-1:0] dp_data,
   output logic              dp_last,
   output logic              rf_write,
   output logic [ADDR_W-1:0] rf_writenum,
   output logic [DATA_W-1:0] rf_data_in,
   output logic [ADDR_W-1:0] rf_readnum,
   input  logic [DATA_W-1:0] rf_data_out,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   state_e            state_q;
   state_e            state_d;
   logic [ADDR_W-1:0] idx_q;
   logic [ADDR_W-1:0] idx_d;
   logic [ADDR_W-1:0] rem_q;
   logic [ADDR_W-1:0] rem_d;
   logic              dp_valid_q;
   logic              dp_valid_d;
   logic              dp_last_q;
   logic              dp_last_d;
   logic              cap;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      rem_d      = rem_q;
      dp_valid_d = dp_valid_q;
      dp_last_d  = dp_last_q;
      cap        = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               idx_d   = cmd_start;
               rem_d   = cmd_len;
               state_d = cmd_op ? ST_DUMP : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (ld_valid) begin
               idx_d = idx_q + ONE;
               rem_d = rem_q - ONE;
               if (rem_q == '0) begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DUMP: begin
            // dp_last_q implies the holder is full with the final beat
            if (dp_last_q) begin
               if (dp_ready) begin
                  state_d    = ST_IDLE;
                  dp_valid_d = 1'b0;
                  dp_last_d  = 1'b0;
               end
            end else if (!dp_valid_q || dp_ready) begin
               cap        = 1'b1;
               dp_valid_d = 1'b1;
               dp_last_d  = (rem_q == '0);
               idx_d      = idx_q + ONE;
               rem_d      = rem_q - ONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         rem_q      <= '0;
         dp_valid_q <= 1'b0;
         dp_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         rem_q      <= rem_d;
         dp_valid_q <= dp_valid_d;
         dp_last_q  <= dp_last_d;
      end
   end

   vdff_w_load #(
      .W (DATA_W)
   ) u_dp_hold (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (cap),
      .d       (rf_data_out),
      .q       (dp_data)
   );

   assign cmd_ready   = (state_q == ST_IDLE);
   assign ld_ready    = (state_q == ST_LOAD);
   assign rf_write    = ld_valid & ld_ready;
   assign rf_writenum = idx_q;
   assign rf_data_in  = ld_data;
   assign rf_readnum  = idx_q;
   assign dp_valid    = dp_valid_q;
   assign dp_last     = dp_last_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_regfile_dbg_seq.sv
// Directed bench for regfile_dbg_seq with a behavioural
// register file hanging off the write/read ports.
module tb_regfile_dbg_seq;

   localparam int DW = 16;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_op;
   logic [AW-1:0] cmd_start;
   logic [AW-1:0] cmd_len;
   logic          ld_valid;
   logic          ld_ready;
   logic [DW-1:0] ld_data;
   logic          dp_valid;
   logic          dp_ready;
   logic [DW-1:0] dp_data;
   logic          dp_last;
   logic          rf_write;
   logic [AW-1:0] rf_writenum;
   logic [DW-1:0] rf_data_in;
   logic [AW-1:0] rf_readnum;
   logic [DW-1:0] rf_data_out;
   logic          busy;

   int tests = 0;
   int fails = 0;
   int viol = 0;

   logic [DW-1:0] regs [8];
   logic [AW-1:0] wn_log [$];
   logic [DW-1:0] wd_log [$];

   regfile_dbg_seq #(
      .DATA_W (DW),
      .ADDR_W (AW)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_start   (cmd_start),
      .cmd_len     (cmd_len),
      .ld_valid    (ld_valid),
      .ld_ready    (ld_ready),
      .ld_data     (ld_data),
      .dp_valid    (dp_valid),
      .dp_ready    (dp_ready),
      .dp_data     (dp_data),
      .dp_last     (dp_last),
      .rf_write    (rf_write),
      .rf_writenum (rf_writenum),
      .rf_data_in  (rf_data_in),
      .rf_readnum  (rf_readnum),
      .rf_data_out (rf_data_out),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   assign rf_data_out = regs[rf_readnum];

   always @(posedge clk) begin
      if (rf_write) begin
         regs[rf_writenum] <= rf_data_in;
         wn_log.push_back(rf_writenum);
         wd_log.push_back(rf_data_in);
      end
      if (rf_write && !(ld_valid && ld_ready)) viol++;
   end

   // Called at posedge+1; returns at posedge+1 just after the handshake edge.
   task automatic do_cmd(input logic op, input int s, input int l);
      int n;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_start = AW'(s);
      cmd_len   = AW'(l);
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n == 50) begin
         tests++;
         fails++;
         $display("FAIL cmd_timeout: cmd_ready stayed %b, required 1", cmd_ready);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic load_beat(input logic [DW-1:0] d, input int gap);
      repeat (gap) begin
         ld_valid = 1'b0;
         ld_data  = 16'hBAD0;
         @(posedge clk); #1;
      end
      ld_valid = 1'b1;
      ld_data  = d;
      @(posedge clk); #1;
      ld_valid = 1'b0;
   endtask

   task automatic run_dump(input bit toggle, input bit ldv,
                           output logic [DW-1:0] dq_o [$],
                           output logic lq_o [$],
                           output int first_k, output int stall_err);
      logic [DW-1:0] dq [$];
      logic          lq [$];
      logic          ps;
      logic [DW-1:0] pd;
      logic          pl;
      bit            done;
      first_k   = -1;
      stall_err = 0;
      ps        = 1'b0;
      pd        = '0;
      pl        = 1'b0;
      done      = 0;
      ld_valid  = ldv;
      ld_data   = 16'hDEAD;
      for (int k = 0; k < 80 && !done; k++) begin
         dp_ready = toggle ? ((k % 3) == 0) : 1'b1;
         if (dp_valid && first_k < 0) first_k = k;
         if (ps && (dp_valid !== 1'b1 || dp_data !== pd || dp_last !== pl))
            stall_err++;
         ps = dp_valid && !dp_ready;
         pd = dp_data;
         pl = dp_last;
         if (dp_valid && dp_ready) begin
            dq.push_back(dp_data);
            lq.push_back(dp_last);
            if (dp_last) done = 1;
         end
         @(posedge clk); #1;
      end
      ld_valid = 1'b0;
      dp_ready = 1'b0;
      dq_o = dq;
      lq_o = lq;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 1'b0;
      cmd_start = '0;
      cmd_len   = '0;
      ld_valid  = 1'b1;
      ld_data   = 16'h5555;
      dp_ready  = 1'b1;
      #12;
      tests++;
      if ({cmd_ready, ld_ready, rf_write, busy} !== 4'b1000) begin
         fails++;
         $display("FAIL reset_ctrl: rdy/ld/wr/busy=%b required 1000",
                  {cmd_ready, ld_ready, rf_write, busy});
      end
      tests++;
      if (rf_writenum !== 3'd0 || rf_readnum !== 3'd0) begin
         fails++;
         $display("FAIL reset_idx: wn=%0d rn=%0d required 0 0",
                  rf_writenum, rf_readnum);
      end
      tests++;
      if (dp_valid !== 1'b0 || dp_last !== 1'b0 || dp_data !== 16'h0) begin
         fails++;
         $display("FAIL reset_dp: v=%b l=%b d=%h required 0 0 0000",
                  dp_valid, dp_last, dp_data);
      end
      @(negedge clk);
      reset_n  = 1'b1;
      ld_valid = 1'b0;
      dp_ready = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_load_wrap();
      logic [DW-1:0] ed [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      logic [AW-1:0] ea [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
      int base;
      base = wn_log.size();
      do_cmd(1'b0, 6, 3);
      tests++;
      if (ld_ready !== 1'b1 || busy !== 1'b1) begin
         fails++;
         $display("FAIL load_enter: ld_ready=%b busy=%b required 1 1",
                  ld_ready, busy);
      end
      for (int i = 0; i < 4; i++) load_beat(ed[i], 0);
      tests++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
         fails++;
         $display("FAIL load_done: busy=%b cmd_ready=%b required 0 1",
                  busy, cmd_ready);
      end
      tests++;
      if (wn_log.size() - base != 4) begin
         fails++;
         $display("FAIL load_count: %0d writes, required 4",
                  wn_log.size() - base);
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests++;
            if (wn_log[base+i] !== ea[i] || wd_log[base+i] !== ed[i]) begin
               fails++;
               $display("FAIL load_write%0d: R%0d=%h required R%0d=%h", i,
                        wn_log[base+i], wd_log[base+i], ea[i], ed[i]);
            end
         end
      end
   endtask

   task automatic test_dump_wrap();
      logic [DW-1:0] ed [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      logic [DW-1:0] dq [$];
      logic          lq [$];
      int            fk;
      int            se;
      dp_ready = 1'b1;
      do_cmd(1'b1, 6, 3);
      run_dump(1'b0, 1'b0, dq, lq, fk, se);
      tests++;
      if (fk != 1) begin
         fails++;
         $display("FAIL dump_latency: first valid at k=%0d, required 1", fk);
      end
      tests++;
      if (dq.size() != 4) begin
         fails++;
         $display("FAIL dump_count: %0d beats, required 4", dq.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests++;
            if (dq[i] !== ed[i] || lq[i] !== (i == 3)) begin
               fails++;
               $display("FAIL dump_beat%0d: %h last=%b required %h last=%b",
                        i, dq[i], lq[i], ed[i], (i == 3));
            end
         end
      end
      tests++;
      if (dp_valid !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL dump_end: dp_valid=%b busy=%b required 0 0",
                  dp_valid, busy);
      end
   endtask

   task automatic test_dump_stall();
      logic [DW-1:0] dq [$];
      logic          lq [$];
      int            fk;
      int            se;
      int            base;
      logic [DW-1:0] exp_d;
      do_cmd(1'b0, 0, 7);
      for (int i = 0; i < 8; i++) load_beat(16'hA000 + 16'(i), 0);
      base = wn_log.size();
      do_cmd(1'b1, 3, 7);
      run_dump(1'b1, 1'b1, dq, lq, fk, se);
      tests++;
      if (dq.size() != 8) begin
         fails++;
         $display("FAIL stall_count: %0d beats, required 8", dq.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            exp_d = 16'hA000 + 16'((i + 3) % 8);
            tests++;
            if (dq[i] !== exp_d || lq[i] !== (i == 7)) begin
               fails++;
               $display("FAIL stall_beat%0d: %h last=%b required %h last=%b",
                        i, dq[i], lq[i], exp_d, (i == 7));
            end
         end
      end
      tests++;
      if (se != 0) begin
         fails++;
         $display("FAIL stall_hold: %0d unstable cycles, required 0", se);
      end
      tests++;
      if (wn_log.size() != base) begin
         fails++;
         $display("FAIL dump_nowrite: %0d writes in dump, required 0",
                  wn_log.size() - base);
      end
   endtask

   task automatic test_load_gaps();
      int base;
      int v0;
      base = wn_log.size();
      v0   = viol;
      do_cmd(1'b0, 2, 2);
      for (int i = 0; i < 3; i++) load_beat(16'hB000 + 16'(i), 2);
      ld_valid = 1'b1;
      ld_data  = 16'hDEAD;
      repeat (3) begin
         @(posedge clk); #1;
      end
      ld_valid = 1'b0;
      tests++;
      if (wn_log.size() - base != 3) begin
         fails++;
         $display("FAIL gap_count: %0d writes, required 3",
                  wn_log.size() - base);
      end else begin
         for (int i = 0; i < 3; i++) begin
            tests++;
            if (wn_log[base+i] !== AW'(2 + i) ||
                wd_log[base+i] !== 16'hB000 + 16'(i)) begin
               fails++;
               $display("FAIL gap_write%0d: R%0d=%h required R%0d=%h", i,
                        wn_log[base+i], wd_log[base+i], 2 + i,
                        16'hB000 + 16'(i));
            end
         end
      end
      tests++;
      if (viol != v0) begin
         fails++;
         $display("FAIL gap_spurious: %0d writes without ld handshake, required 0",
                  viol - v0);
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] dq [$];
      logic          lq [$];
      int            fk;
      int            se;
      int            base;
      base = wn_log.size();
      do_cmd(1'b0, 0, 4);
      load_beat(16'hC000, 0);
      load_beat(16'hC001, 0);
      ld_valid = 1'b1;
      ld_data  = 16'hC002;
      #1;
      tests++;
      if (rf_write !== 1'b1) begin
         fails++;
         $display("FAIL rst_pre: rf_write=%b required 1", rf_write);
      end
      #1;
      reset_n = 1'b0;
      #1;
      tests++;
      if ({rf_write, busy, cmd_ready, ld_ready} !== 4'b0010) begin
         fails++;
         $display("FAIL rst_mid: wr/busy/rdy/ld=%b required 0010",
                  {rf_write, busy, cmd_ready, ld_ready});
      end
      @(posedge clk); #1;
      @(negedge clk);
      reset_n  = 1'b1;
      ld_valid = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (wn_log.size() - base != 2) begin
         fails++;
         $display("FAIL rst_writes: %0d writes, required 2",
                  wn_log.size() - base);
      end
      do_cmd(1'b1, 0, 0);
      run_dump(1'b0, 1'b0, dq, lq, fk, se);
      tests++;
      if (dq.size() != 1 || dq[0] !== 16'hC000 || lq[0] !== 1'b1) begin
         fails++;
         $display("FAIL rst_dump: %0d beats first=%h, required 1 beat C000 last",
                  dq.size(), (dq.size() > 0) ? dq[0] : 16'h0);
      end
   endtask

   task automatic test_cmd_hold();
      logic [DW-1:0] dq [$];
      logic          lq [$];
      int            fk;
      int            se;
      int            bad;
      bad       = 0;
      cmd_valid = 1'b1;
      cmd_op    = 1'b0;
      cmd_start = 3'd5;
      cmd_len   = 3'd1;
      @(posedge clk); #1;
      cmd_op = 1'b1;
      repeat (3) begin
         if (cmd_ready !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      ld_valid = 1'b1;
      ld_data  = 16'hD000;
      if (cmd_ready !== 1'b0) bad++;
      @(posedge clk); #1;
      ld_data = 16'hD001;
      if (cmd_ready !== 1'b0) bad++;
      @(posedge clk); #1;
      ld_valid = 1'b0;
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL hold_busy: cmd_ready high %0d busy cycles, required 0",
                  bad);
      end
      tests++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL hold_idle: cmd_ready=%b busy=%b required 1 0",
                  cmd_ready, busy);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      tests++;
      if (busy !== 1'b1 || ld_ready !== 1'b0) begin
         fails++;
         $display("FAIL hold_accept: busy=%b ld_ready=%b required 1 0",
                  busy, ld_ready);
      end
      run_dump(1'b0, 1'b0, dq, lq, fk, se);
      tests++;
      if (dq.size() != 2 || dq[0] !== 16'hD000 || dq[1] !== 16'hD001 ||
          lq[0] !== 1'b0 || lq[1] !== 1'b1 || fk != 1) begin
         fails++;
         $display("FAIL hold_dump: %0d beats k=%0d, required D000 D001 last on 2nd k=1",
                  dq.size(), fk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_load_wrap();
      test_dump_wrap();
      test_dump_stall();
      test_load_gaps();
      test_reset_mid();
      test_cmd_hold();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
